// File: rtl/data_memory_sized.sv
// Data memory for the MEM stage: RV32I sized loads/stores over a word array,
// valid/ready request port, registered 1-cycle response, and a self-clear
// sweep of the array after every reset before traffic is accepted.
module data_memory_sized #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned IDX_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  init_done
);

  // One extra bit so the pointer can express "past the last word" without wrapping.
  localparam int unsigned PTR_WIDTH = IDX_WIDTH + 1;
  localparam logic [PTR_WIDTH-1:0] LAST_PTR = PTR_WIDTH'(DEPTH_WORDS - 1);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic [PTR_WIDTH-1:0]   clear_ptr_q;
  logic [PTR_WIDTH-1:0]   clear_ptr_d;
  logic                   ready_d;
  logic                   done_d;
  logic                   rsp_valid_d;
  logic                   rsp_err_d;
  logic [31:0]            rsp_rdata_d;

  logic [31:0]            mem [DEPTH_WORDS];

  logic                   xfer_c;
  logic [IDX_WIDTH-1:0]   word_idx_c;
  logic                   oor_c;
  logic                   misaligned_c;
  logic                   illegal_c;
  logic                   err_c;
  logic [31:0]            rd_word_c;
  logic [7:0]             lane_byte_c;
  logic [15:0]            lane_half_c;
  logic [31:0]            load_ext_c;
  logic [3:0]             be_c;
  logic [31:0]            wlane_c;
  logic [31:0]            merged_c;
  logic                   wr_en_c;
  logic [IDX_WIDTH-1:0]   wr_idx_c;
  logic [31:0]            wr_data_c;

  assign xfer_c     = req_valid & req_ready;
  assign word_idx_c = req_addr[IDX_WIDTH+1:2];
  assign oor_c      = |req_addr[ADDR_WIDTH-1:IDX_WIDTH+2];
  assign rd_word_c  = mem[word_idx_c];

  // Request legality: alignment, funct3 encoding, and address range.
  always_comb begin : decode_err
    misaligned_c = 1'b0;
    illegal_c    = 1'b0;
    case (req_funct3)
      F3_H, F3_HU: misaligned_c = req_addr[0];
      F3_W:        misaligned_c = |req_addr[1:0];
      default:     misaligned_c = 1'b0;
    endcase
    case (req_funct3)
      F3_B, F3_H, F3_W: illegal_c = 1'b0;
      F3_BU, F3_HU:     illegal_c = req_we;
      default:          illegal_c = 1'b1;
    endcase
    err_c = oor_c | misaligned_c | illegal_c;
  end

  // Select the addressed lane of the read word and extend it to 32 bits.
  always_comb begin : load_extend
    lane_byte_c = 8'h00;
    case (req_addr[1:0])
      2'd0:    lane_byte_c = rd_word_c[7:0];
      2'd1:    lane_byte_c = rd_word_c[15:8];
      2'd2:    lane_byte_c = rd_word_c[23:16];
      default: lane_byte_c = rd_word_c[31:24];
    endcase
    lane_half_c = req_addr[1] ? rd_word_c[31:16] : rd_word_c[15:0];
    load_ext_c  = '0;
    case (req_funct3)
      F3_B:    load_ext_c = {{24{lane_byte_c[7]}}, lane_byte_c};
      F3_BU:   load_ext_c = {24'h000000, lane_byte_c};
      F3_H:    load_ext_c = {{16{lane_half_c[15]}}, lane_half_c};
      F3_HU:   load_ext_c = {16'h0000, lane_half_c};
      F3_W:    load_ext_c = rd_word_c;
      default: load_ext_c = '0;
    endcase
  end

  // Byte-lane enables for stores, and the read word merged with the new lanes.
  always_comb begin : store_merge
    be_c    = 4'b0000;
    wlane_c = req_wdata;
    case (req_funct3)
      F3_B: begin
        be_c    = 4'b0001 << req_addr[1:0];
        wlane_c = {4{req_wdata[7:0]}};
      end
      F3_H: begin
        be_c    = req_addr[1] ? 4'b1100 : 4'b0011;
        wlane_c = {2{req_wdata[15:0]}};
      end
      F3_W:    be_c = 4'b1111;
      default: be_c = 4'b0000;
    endcase
    for (int i = 0; i < 4; i++) begin
      merged_c[8*i +: 8] = be_c[i] ? wlane_c[8*i +: 8] : rd_word_c[8*i +: 8];
    end
  end

  // Single write port: the clear sweep owns it during INIT, legal stores in RUN.
  always_comb begin : write_port
    wr_en_c   = 1'b0;
    wr_idx_c  = word_idx_c;
    wr_data_c = merged_c;
    if (state_q == ST_INIT) begin
      wr_en_c   = 1'b1;
      wr_idx_c  = clear_ptr_q[IDX_WIDTH-1:0];
      wr_data_c = '0;
    end else if (xfer_c && req_we && !err_c) begin
      wr_en_c = 1'b1;
    end
  end

  // Array storage; contents are deliberately not touched by reset.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem[wr_idx_c] <= wr_data_c;
    end
  end

  // Next state, clear pointer and next values of the registered outputs.
  always_comb begin : fsm_next
    state_d     = state_q;
    clear_ptr_d = clear_ptr_q;
    ready_d     = 1'b0;
    done_d      = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    case (state_q)
      ST_INIT: begin
        clear_ptr_d = clear_ptr_q + PTR_WIDTH'(1);
        if (clear_ptr_q == LAST_PTR) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
    ready_d     = (state_d == ST_RUN);
    done_d      = (state_d == ST_RUN);
    rsp_valid_d = xfer_c;
    rsp_err_d   = xfer_c & err_c;
    if (xfer_c && !err_c && !req_we) begin
      rsp_rdata_d = load_ext_c;
    end
  end

  // State, pointer and output registers; reset drops any in-flight response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_INIT;
      clear_ptr_q <= '0;
      req_ready   <= 1'b0;
      init_done   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_rdata   <= '0;
    end else begin
      state_q     <= state_d;
      clear_ptr_q <= clear_ptr_d;
      req_ready   <= ready_d;
      init_done   <= done_d;
      rsp_valid   <= rsp_valid_d;
      rsp_err     <= rsp_err_d;
      rsp_rdata   <= rsp_rdata_d;
    end
  end

endmodule

// File: tb/tb_data_memory_sized.sv
// Bench for data_memory_sized: directed vector table, random traffic against a
// byte-addressed reference memory, and init / reset-mid-stream sequences.
module tb_data_memory_sized;

  localparam int unsigned DEPTH  = 256;
  localparam int unsigned NBYTES = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        init_done;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] refb [NBYTES];

  typedef struct {
    logic        v;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  data_memory_sized #(
    .ADDR_WIDTH (32),
    .DEPTH_WORDS(256),
    .IDX_WIDTH  (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_funct3(req_funct3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .init_done (init_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic void clear_model();
    for (int i = 0; i < int'(NBYTES); i++) refb[i] = 8'h00;
  endfunction

  // Reference: little-endian byte memory, access size from funct3.
  function automatic void model(input logic v, input logic we, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic ev, output logic ee, output logic [31:0] erd);
    int unsigned sz;
    logic        illegal;
    logic [31:0] val;
    ev  = v;
    ee  = 1'b0;
    erd = 32'h0;
    if (!v) return;
    illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) ||
              (we && (f3 == 3'd4 || f3 == 3'd5));
    case (f3)
      3'd0, 3'd4: sz = 1;
      3'd1, 3'd5: sz = 2;
      3'd2:       sz = 4;
      default:    sz = 1;
    endcase
    if (illegal || a >= NBYTES || (a % sz) != 0) begin
      ee = 1'b1;
      return;
    end
    if (we) begin
      for (int i = 0; i < int'(sz); i++) refb[a + i] = wd[8*i +: 8];
    end else begin
      val = 32'h0;
      for (int i = 0; i < int'(sz); i++) val = val | (32'(refb[a + i]) << (8*i));
      if (f3 < 3'd4 && sz < 4 && val[8*sz-1]) val = val | ~((32'h1 << (8*sz)) - 32'h1);
      erd = val;
    end
  endfunction

  // Drive one cycle of request inputs and step to just after the edge.
  task automatic issue(input logic v, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    req_valid  = v;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk);
    #1;
  endtask

  // Count edges until req_ready rises; bounded, -1 on timeout.
  task automatic wait_init(output int cyc, output int bad);
    cyc = -1;
    bad = 0;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk);
      #1;
      if (req_ready) begin
        cyc = k;
        break;
      end
      if (init_done || rsp_valid) bad++;
    end
  endtask

  function automatic void add(input logic v, input logic we, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic ee, input logic [31:0] erd);
    vec_t t;
    t.v = v; t.we = we; t.f3 = f3; t.addr = a; t.wdata = wd;
    t.exp_err = ee; t.exp_rdata = erd;
    vecs.push_back(t);
  endfunction

  initial begin
    int          cyc;
    int          bad;
    logic        ev;
    logic        ee;
    logic [31:0] erd;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    clear_model();

    // Reset state
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_done",  32'(init_done), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold_ready", 32'(req_ready), 32'd0);

    // T1: requests during init are ignored; ready after exactly 256 cycles
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h0; req_wdata = 32'hFFFF_FFFF;
    rst = 1'b0;
    wait_init(cyc, bad);
    chk("init_cycles", 32'(cyc), 32'd256);
    chk("init_quiet", 32'(bad), 32'd0);
    chk("init_done", 32'(init_done), 32'd1);
    issue(1'b1, 1'b0, 3'b010, 32'h3FC, 32'h0);
    chk("t1_lw_valid", 32'(rsp_valid), 32'd1);
    chk("t1_lw_rdata", rsp_rdata, 32'h0);
    chk("t1_lw_err", 32'(rsp_err), 32'd0);
    issue(1'b1, 1'b0, 3'b010, 32'h0, 32'h0);
    chk("t1_lw0_rdata", rsp_rdata, 32'h0);

    // Directed table: T2..T5 plus extra illegal/misaligned cases
    add(1, 1, 3'b010, 32'h10,  32'h11223344, 0, 32'h0);
    add(1, 1, 3'b000, 32'h11,  32'h000000AB, 0, 32'h0);
    add(1, 0, 3'b000, 32'h11,  32'h0,        0, 32'hFFFFFFAB);
    add(1, 0, 3'b100, 32'h11,  32'h0,        0, 32'h000000AB);
    add(1, 0, 3'b001, 32'h12,  32'h0,        0, 32'h00001122);
    add(1, 0, 3'b010, 32'h10,  32'h0,        0, 32'h1122AB44);
    add(1, 0, 3'b010, 32'h02,  32'h0,        1, 32'h0);
    add(1, 1, 3'b010, 32'h20,  32'h55667788, 0, 32'h0);
    add(1, 1, 3'b001, 32'h21,  32'h0000BEEF, 1, 32'h0);
    add(1, 0, 3'b010, 32'h20,  32'h0,        0, 32'h55667788);
    add(1, 0, 3'b011, 32'h20,  32'h0,        1, 32'h0);
    add(1, 0, 3'b010, 32'h400, 32'h0,        1, 32'h0);
    add(1, 1, 3'b010, 32'h40,  32'hDEADBEEF, 0, 32'h0);
    add(1, 0, 3'b010, 32'h40,  32'h0,        0, 32'hDEADBEEF);
    add(1, 1, 3'b001, 32'h50,  32'h00008001, 0, 32'h0);
    add(1, 0, 3'b001, 32'h50,  32'h0,        0, 32'hFFFF8001);
    add(0, 0, 3'b010, 32'h40,  32'h0,        0, 32'h0);
    add(1, 0, 3'b101, 32'h50,  32'h0,        0, 32'h00008001);
    add(1, 1, 3'b100, 32'h50,  32'h12345678, 1, 32'h0);
    add(1, 0, 3'b101, 32'h51,  32'h0,        1, 32'h0);
    add(1, 1, 3'b000, 32'h53,  32'h000000C3, 0, 32'h0);
    add(1, 0, 3'b010, 32'h50,  32'h0,        0, 32'hC3008001);
    add(1, 0, 3'b000, 32'hFFFF_0010, 32'h0,  1, 32'h0);
    for (int i = 0; i < vecs.size(); i++) begin
      issue(vecs[i].v, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata);
      model(vecs[i].v, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, ev, ee, erd);
      chk($sformatf("vec%0d_valid", i), 32'(rsp_valid), 32'(vecs[i].v));
      chk($sformatf("vec%0d_err", i),   32'(rsp_err),   32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_rdata", i), rsp_rdata,      vecs[i].exp_rdata);
    end

    // Random traffic against the reference model
    for (int n = 0; n < 2000; n++) begin
      logic        v;
      logic        we;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] wd;
      int unsigned r;
      v  = ($urandom_range(0, 9) != 0);
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      r  = $urandom_range(0, 19);
      if (r == 0)      a = $urandom;
      else if (r == 1) a = 32'(NBYTES) + 32'($urandom_range(0, 64));
      else             a = 32'($urandom_range(0, 127));
      wd = $urandom;
      issue(v, we, f3, a, wd);
      model(v, we, f3, a, wd, ev, ee, erd);
      chk($sformatf("rnd%0d_valid", n), 32'(rsp_valid), 32'(ev));
      chk($sformatf("rnd%0d_err", n),   32'(rsp_err),   32'(ee));
      chk($sformatf("rnd%0d_rdata", n), rsp_rdata,      erd);
    end

    // T6: reset while a load response is out; array is cleared again
    issue(1'b1, 1'b1, 3'b010, 32'h10, 32'h12345678);
    issue(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    chk("t6_pre_valid", 32'(rsp_valid), 32'd1);
    chk("t6_pre_rdata", rsp_rdata, 32'h12345678);
    rst = 1'b1;
    #1;
    chk("t6_drop_valid", 32'(rsp_valid), 32'd0);
    chk("t6_drop_rdata", rsp_rdata, 32'h0);
    chk("t6_drop_ready", 32'(req_ready), 32'd0);
    chk("t6_drop_done",  32'(init_done), 32'd0);
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_model();
    wait_init(cyc, bad);
    chk("t6_init_cycles", 32'(cyc), 32'd256);
    chk("t6_init_quiet", 32'(bad), 32'd0);
    issue(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    chk("t6_lw_valid", 32'(rsp_valid), 32'd1);
    chk("t6_lw_rdata", rsp_rdata, 32'h0);
    issue(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    chk("t6_idle_valid", 32'(rsp_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
